// File: rtl/seq_mult_8x8_ctrl.sv
// rtl/seq_mult_8x8_ctrl.sv - sequential 8x8 unsigned shift-add multiplier with start/done handshake
// Optional build macro ZERO_SKIP_EN: a zero operand completes in one cycle without iterating.
module seq_mult_8x8_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   add_res;
    logic             last_iter;
    logic             zero_op;

    // Single shared adder; the carry-out is kept as the 9th bit so 255*255 does not truncate.
    assign add_res   = q[0] ? ({1'b0, acc} + {1'b0, m}) : {1'b0, acc};
    assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start ? (zero_op ? DONE : RUN) : IDLE;
            RUN:     state_next = last_iter ? DONE : RUN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            m       <= '0;
            q       <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        q   <= b;
                        acc <= '0;
                        cnt <= '0;
                        if (zero_op) begin
                            product <= '0;
                        end
                    end
                end
                RUN: begin
                    {acc, q} <= {add_res, q[WIDTH-1:1]};
                    cnt      <= cnt + CW'(1);
                    if (last_iter) begin
                        product <= {add_res, q[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags come straight from the state register, never from start.
    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_seq_mult_8x8_ctrl.sv
// tb/tb_seq_mult_8x8_ctrl.sv - self-checking bench for seq_mult_8x8_ctrl (honours ZERO_SKIP_EN)
module tb_seq_mult_8x8_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] sb[$];
    logic [15:0] last_prod = 16'h0000;

    seq_mult_8x8_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [7:0] xa, input logic [7:0] xb);
`ifdef ZERO_SKIP_EN
        return (xa == 8'd0 || xb == 8'd0) ? 1 : 9;
`else
        return 9;
`endif
    endfunction

    // Launch one multiply from IDLE and collect what the DUT does; comparisons live in the callers.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb,
                          output int lat, output int bcnt,
                          output logic [15:0] prod, output logic after_ok);
        logic found;
        found    = 1'b0;
        lat      = 0;
        bcnt     = 0;
        prod     = 16'hxxxx;
        after_ok = 1'b0;
        @(negedge clk);
        a     = xa;
        b     = xb;
        start = 1'b1;
        sb.push_back(16'(xa) * 16'(xb));
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            a     = 8'($urandom);
            b     = 8'($urandom);
            if (busy) bcnt++;
            if (done) begin
                found = 1'b1;
                prod  = product;
            end
        end
        if (!found) begin
            lat = -1;
        end else begin
            @(negedge clk);
            after_ok = !done && ready && (product === prod);
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags: got rdy/busy/done=%b expected 100", {ready, busy, done});
        end
        checks++;
        if (product !== 16'h0000) begin
            failures++;
            $display("FAIL reset_product: got %h expected 0000", product);
        end
    endtask

    task automatic test_mult(input logic [7:0] xa, input logic [7:0] xb, input string name);
        int          lat;
        int          bcnt;
        logic [15:0] prod;
        logic        after_ok;
        logic [15:0] exp;
        run_op(xa, xb, lat, bcnt, prod, after_ok);
        exp = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        checks++;
        if (prod !== exp) begin
            failures++;
            $display("FAIL %s_product: got %0d expected %0d", name, prod, exp);
        end
        checks++;
        if (lat != exp_lat(xa, xb)) begin
            failures++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat(xa, xb));
        end
        checks++;
        if (bcnt != exp_lat(xa, xb) - 1) begin
            failures++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", name, bcnt, exp_lat(xa, xb) - 1);
        end
        checks++;
        if (!after_ok) begin
            failures++;
            $display("FAIL %s_done_pulse: got done/ready/product not (0,1,held) after done, expected single pulse", name);
        end
        last_prod = exp;
    endtask

    task automatic test_ignore_start;
        int          ndone = 0;
        int          busy_after = 0;
        logic [15:0] got = 16'hxxxx;
        logic [15:0] mid = 16'hxxxx;
        logic [15:0] exp;
        @(negedge clk);
        a     = 8'd20;
        b     = 8'd30;
        start = 1'b1;
        sb.push_back(16'd600);
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 8 || k == 9);
            a     = start ? 8'd7 : 8'($urandom);
            b     = start ? 8'd7 : 8'($urandom);
            if (k == 4) mid = product;
            if (done) begin
                ndone++;
                got = product;
            end else if (ndone != 0 && busy) begin
                busy_after++;
            end
        end
        exp = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        checks++;
        if (mid !== last_prod) begin
            failures++;
            $display("FAIL ignore_prev_held: got %0d expected %0d", mid, last_prod);
        end
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL ignore_product: got %0d expected %0d", got, exp);
        end
        checks++;
        if (ndone != 1 || busy_after != 0) begin
            failures++;
            $display("FAIL ignore_single_done: got done=%0d extra_busy=%0d expected 1 and 0", ndone, busy_after);
        end
        checks++;
        if (product !== 16'd600 || ready !== 1'b1) begin
            failures++;
            $display("FAIL ignore_hold: got product=%0d ready=%b expected 600 and 1", product, ready);
        end
        last_prod = exp;
    endtask

    task automatic test_reset_mid_run;
        int ndone = 0;
        @(negedge clk);
        a     = 8'd100;
        b     = 8'd100;
        start = 1'b1;
        sb.push_back(16'd10000);
        @(posedge clk);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = (k == 4);
            if (done) ndone++;
            if (k == 5) begin
                checks++;
                if ({ready, busy, done} !== 3'b100 || product !== 16'h0000) begin
                    failures++;
                    $display("FAIL rst_mid_run: got rdy/busy/done=%b product=%h expected 100 and 0000",
                             {ready, busy, done}, product);
                end
            end
        end
        sb.delete();
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL rst_no_done: got %0d done pulses expected 0", ndone);
        end
        last_prod = 16'h0000;
        test_mult(8'd12, 8'd12, "after_rst");
    endtask

    task automatic test_back_to_back;
        int          n_acc = 0;
        int          n_done = 0;
        int          guard = 0;
        int          last_acc = 0;
        int          exp_int = 10;
        logic [15:0] exp;
        @(negedge clk);
        start = 1'b1;
        a     = 8'($urandom);
        b     = 8'($urandom);
        while (n_done < 1000 && guard < 15000) begin
            if (ready && start) begin
                if (n_acc > 0) begin
                    checks++;
                    if (guard - last_acc != exp_int) begin
                        failures++;
                        $display("FAIL b2b_interval: got %0d expected %0d at txn %0d", guard - last_acc, exp_int, n_acc);
                    end
                end
                sb.push_back(16'(a) * 16'(b));
                exp_int  = exp_lat(a, b) + 1;
                last_acc = guard;
                n_acc++;
            end
            @(posedge clk);
            guard++;
            @(negedge clk);
            if (done) begin
                exp = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
                checks++;
                if (product !== exp) begin
                    failures++;
                    $display("FAIL b2b_product: got %0d expected %0d at txn %0d", product, exp, n_done);
                end
                n_done++;
            end
            if (!ready) begin
                a = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
                b = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom);
            end
            if (n_acc >= 1000) start = 1'b0;
        end
        checks++;
        if (n_done != 1000) begin
            failures++;
            $display("FAIL b2b_timeout: got %0d completions expected 1000", n_done);
        end
    endtask

    initial begin
        test_reset();
        test_mult(8'd13, 8'd11, "m13x11");
        test_mult(8'd255, 8'd255, "m255x255");
        test_mult(8'd255, 8'd1, "m255x1");
        test_mult(8'd1, 8'd255, "m1x255");
        test_mult(8'd0, 8'd200, "m0x200");
        test_mult(8'd13, 8'd11, "m13x11_again");
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
